mix_columns_iter: RTL

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

---
 rtl/aes_pkg.sv | 32 +++
 rtl/mix_column_word.sv | 26 ++
 rtl/mix_columns_iter.sv | 111 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, the reduction constant and the
// state encoding used by the iterative MixColumns engine.
package aes_pkg;

  localparam logic [7:0] GF_REDUCE = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
  endfunction

  // Only the MixColumns coefficients (at most 0x0E) are needed, so four
  // multiplier bits are enough.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational single-column (32-bit) MixColumns / InvMixColumns.
// Row 0 is the most significant byte of the column.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a [4];
  logic [7:0] b [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r] = col_in[31-8*r -: 8];

    assign b[r] = inv
      ? gf_mul(a[r], 4'hE) ^ gf_mul(a[(r+1)%4], 4'hB) ^
        gf_mul(a[(r+2)%4], 4'hD) ^ gf_mul(a[(r+3)%4], 4'h9)
      : gf_mul(a[r], 4'h2) ^ gf_mul(a[(r+1)%4], 4'h3) ^
        a[(r+2)%4] ^ a[(r+3)%4];
  end

  assign col_out = {b[0], b[1], b[2], b[3]};

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns engine: transforms COLS_PER_CYCLE columns of the
// 128-bit state per busy cycle, with valid/ready handshakes on both sides.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // A step of 4 truncates to 0, so the counter simply stays put at full width.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic [127:0]   work_q, work_d;

  logic [31:0]    cols     [4];
  logic [31:0]    upd      [4];
  logic [1:0]     col_idx  [COLS_PER_CYCLE];
  logic [31:0]    col_in   [COLS_PER_CYCLE];
  logic [31:0]    col_out  [COLS_PER_CYCLE];
  logic [127:0]   work_busy;

  for (genvar c = 0; c < 4; c++) begin : g_split
    assign cols[c] = work_q[127-32*c -: 32];
  end

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    assign col_idx[i] = cnt_q + 2'(i);
    assign col_in[i]  = cols[col_idx[i]];

    mix_column_word u_word (
      .col_in  (col_in[i]),
      .inv     (mode_q),
      .col_out (col_out[i])
    );
  end

  // NOTE: every combinational output gets a default before any conditional
  // write; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    for (int c = 0; c < 4; c++) upd[c] = cols[c];
    for (int i = 0; i < COLS_PER_CYCLE; i++) upd[col_idx[i]] = col_out[i];
  end

  assign work_busy = {upd[0], upd[1], upd[2], upd[3]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          cnt_d   = 2'd0;
          mode_d  = in_inv;
          work_d  = in_block;
        end
      end
      BUSY: begin
        work_d = work_busy;
        cnt_d  = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      mode_q  <= 1'b0;
      // NOTE: the work register is reset on purpose: out_block is driven
      // straight from it and must read zero during and after reset.
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_block = work_q;

endmodule
